ps2_receiver: RTL and testbench

Receives PS/2 keyboard frames and turns set-2 scan codes into the held-key code consumed by the VGA plotter's `character` input. It sits directly upstream of the plotter and runs in the same system clock domain. While a key is held, `character` carries that key's make code; on release it returns to 8'h00. The plotter treats 8'h00 as "no key pressed".

---
 rtl/ps2_receiver.sv | 191 +++++++++++++++++++
 tb/tb_ps2_receiver.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 keyboard frame receiver with set-2 make/break decoding.
// Drives the held-key make code on `character` (8'h00 when no key is held).
// Optional feature macro: PS2_PARITY_CHECK_EN (reject frames with bad odd parity).
module ps2_receiver #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] character,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Input path registers
    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          data_s1_q, data_s2_q;
    logic          fall_q;
    logic          bit_q;

    // Frame and decode state
    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    char_q, char_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic          bv_q, bv_d;
    logic          fe_q, fe_d;
    logic          parity_ok;
    logic          timeout;

`ifdef PS2_PARITY_CHECK_EN
    logic          parity_q, parity_d;
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    // Synchronize pins and register a falling-edge pulse with its aligned data bit.
    // The sync/edge flops reset low so a pin held low across reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1_q   <= 1'b0;
            clk_s2_q   <= 1'b0;
            clk_prev_q <= 1'b0;
            data_s1_q  <= 1'b0;
            data_s2_q  <= 1'b0;
            fall_q     <= 1'b0;
            bit_q      <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= ps2_data;
            data_s2_q  <= data_s1_q;
            fall_q     <= ~clk_s2_q & clk_prev_q;
            bit_q      <= data_s2_q;
        end
    end

    // Frame FSM, timeout counter and scan-code decode state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            char_q   <= '0;
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            bv_q     <= 1'b0;
            fe_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            char_q   <= char_d;
            brk_q    <= brk_d;
            ext_q    <= ext_d;
            bv_q     <= bv_d;
            fe_q     <= fe_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state: timeout has priority over a coincident edge; stop bit accepts and decodes.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        char_d   = char_q;
        brk_d    = brk_q;
        ext_d    = ext_q;
        bv_d     = 1'b0;
        fe_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d = parity_q;
`endif
        timeout  = (state_q != S_IDLE) && (cnt_q == TO_LIMIT);

        if (timeout) begin
            state_d  = S_IDLE;
            fe_d     = 1'b1;
            shift_d  = '0;
            bitcnt_d = '0;
        end else begin
            if (fall_q) begin
                cnt_d = '0;
            end else if ((state_q != S_IDLE) && (cnt_q != TO_LIMIT)) begin
                cnt_d = cnt_q + 1'b1;
            end

            if (fall_q) begin
                case (state_q)
                    S_IDLE: begin
                        if (!bit_q) begin
                            state_d  = S_DATA;
                            bitcnt_d = '0;
                            shift_d  = '0;
                        end else begin
                            fe_d = 1'b1;
                        end
                    end
                    S_DATA: begin
                        shift_d  = {bit_q, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end
                    S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_d = bit_q;
`endif
                        state_d = S_STOP;
                    end
                    S_STOP: begin
                        state_d = S_IDLE;
                        if (bit_q && parity_ok) begin
                            bv_d = 1'b1;
                            if (shift_q == 8'hF0) begin
                                brk_d = 1'b1;
                            end else if (shift_q == 8'hE0) begin
                                ext_d = 1'b1;
                            end else if (brk_q) begin
                                if (shift_q == char_q) begin
                                    char_d = 8'h00;
                                end
                                brk_d = 1'b0;
                                ext_d = 1'b0;
                            end else begin
                                if (!ext_q) begin
                                    char_d = shift_q;
                                end
                                ext_d = 1'b0;
                            end
                        end else begin
                            fe_d = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    assign character   = char_q;
    assign byte_valid  = bv_q;
    assign frame_error = fe_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Testbench for ps2_receiver: directed table, timing/timeout/reset sequences,
// then random frames checked against a scan-code reference model.
module tb_ps2_receiver;

    localparam int TO   = 200;
    localparam int HALF = 40;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] character;
    logic       byte_valid;
    logic       frame_error;

    ps2_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .character  (character),
        .byte_valid (byte_valid),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int bv_cnt = 0;
    int fe_cnt = 0;
    int fe_last_cyc = -1;
    int last_fall = 0;
    int total = 0;
    int bad = 0;

    // Reference model state
    logic [7:0] m_char = 8'h00;
    bit         m_brk = 1'b0;
    bit         m_ext = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Count output pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (byte_valid) bv_cnt++;
        if (frame_error) begin
            fe_cnt++;
            fe_last_cyc = cyc;
        end
    end

    typedef struct {
        int         kind;      // 0 = frame, 1 = lone edge with data high
        logic [7:0] data;
        bit         par_bad;
        bit         stop_bad;
        logic [7:0] exp_char;
        int         exp_bv;
        int         exp_fe;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        last_fall = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
        logic p;
        p = (~^b) ^ par_bad;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(~stop_bad);
        ps2_data = 1'b1;
    endtask

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            if (m_brk) begin
                if (b == m_char) m_char = 8'h00;
            end else if (!m_ext) begin
                m_char = b;
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endfunction

    // Send one vector, advance the model, compare pulse counts and character.
    task automatic run_vec(input string name, input vec_t v);
        int  bv0, fe0;
        bit  acc;
        bv0 = bv_cnt;
        fe0 = fe_cnt;
        if (v.kind == 1) begin
            send_bit(1'b1);
        end else begin
            send_frame(v.data, v.par_bad, v.stop_bad);
            acc = !v.stop_bad && !(v.par_bad && CHK);
            if (acc) model_byte(v.data);
        end
        wait_cyc(10);
        check({name, ".bv"}, bv_cnt - bv0, v.exp_bv);
        check({name, ".fe"}, fe_cnt - fe0, v.exp_fe);
        check({name, ".char"}, int'(character), int'(v.exp_char));
    endtask

    vec_t tbl[$];

    function automatic vec_t mk(input int kind, input logic [7:0] d, input bit pb, input bit sb,
                                input logic [7:0] ec, input int ebv, input int efe);
        vec_t v;
        v.kind = kind; v.data = d; v.par_bad = pb; v.stop_bad = sb;
        v.exp_char = ec; v.exp_bv = ebv; v.exp_fe = efe;
        return v;
    endfunction

    initial begin
        int         k;
        int         fe0, bv0;
        logic [7:0] b;
        vec_t       v;

        // Directed table, starting from character = 32 with no pending prefixes
        tbl.push_back(mk(0, 8'hF0, 0, 0, 8'h32, 1, 0));
        tbl.push_back(mk(0, 8'h32, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h34, 0, 0, 8'h34, 1, 0));
        tbl.push_back(mk(0, 8'hF0, 0, 0, 8'h34, 1, 0));
        tbl.push_back(mk(0, 8'h2E, 0, 0, 8'h34, 1, 0));
        tbl.push_back(mk(0, 8'h2E, 0, 0, 8'h2E, 1, 0));
        tbl.push_back(mk(0, 8'hE0, 0, 0, 8'h2E, 1, 0));
        tbl.push_back(mk(0, 8'h75, 0, 0, 8'h2E, 1, 0));
        tbl.push_back(mk(0, 8'hE0, 0, 0, 8'h2E, 1, 0));
        tbl.push_back(mk(0, 8'hF0, 0, 0, 8'h2E, 1, 0));
        tbl.push_back(mk(0, 8'h75, 0, 0, 8'h2E, 1, 0));
        tbl.push_back(mk(0, 8'h32, 0, 0, 8'h32, 1, 0));
        tbl.push_back(mk(0, 8'h2E, 1, 0, CHK ? 8'h32 : 8'h2E, CHK ? 0 : 1, CHK ? 1 : 0));
        tbl.push_back(mk(0, 8'h34, 0, 1, CHK ? 8'h32 : 8'h2E, 0, 1));
        tbl.push_back(mk(1, 8'h00, 0, 0, CHK ? 8'h32 : 8'h2E, 0, 1));
        tbl.push_back(mk(0, 8'h1C, 0, 0, 8'h1C, 1, 0));
        tbl.push_back(mk(0, 8'h1C, 0, 0, 8'h1C, 1, 0));

        // Reset values
        wait_cyc(4);
        @(negedge clk);
        check("rst.char", int'(character), 0);
        check("rst.bv", int'(byte_valid), 0);
        check("rst.fe", int'(frame_error), 0);
        rst_n = 1'b1;
        wait_cyc(20);

        // Make code 32: character and byte_valid change 4 cycles after the stop-bit pin edge
        b = 8'h32;
        bv0 = bv_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(1'b0);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        k = cyc;
        do @(negedge clk); while (cyc < k + 3);
        check("lat.char_before", int'(character), 8'h00);
        check("lat.bv_before", int'(byte_valid), 0);
        @(negedge clk);
        check("lat.char_at", int'(character), 8'h32);
        check("lat.bv_at", int'(byte_valid), 1);
        @(negedge clk);
        check("lat.bv_after", int'(byte_valid), 0);
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(10);
        check("lat.bv_count", bv_cnt - bv0, 1);
        model_byte(8'h32);

        foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Timeout: start + 4 data bits, then the clock stops
        fe0 = fe_cnt;
        bv0 = bv_cnt;
        b = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        ps2_data = 1'b1;
        k = last_fall;
        for (int i = 0; i < 300 && fe_cnt == fe0; i++) @(negedge clk);
        wait_cyc(5);
        check("to.fe_count", fe_cnt - fe0, 1);
        check("to.bv_count", bv_cnt - bv0, 0);
        // Edge declared at pin+3; error expected ~200 cycles later, small slack either way
        check("to.window", int'(fe_last_cyc >= k + 200 && fe_last_cyc <= k + 206), 1);
        check("to.char", int'(character), int'(m_char));
        run_vec("to.next", mk(0, 8'h34, 0, 0, 8'h34, 1, 0));

        // Reset mid-frame while holding 32
        run_vec("mr.pre", mk(0, 8'h32, 0, 0, 8'h32, 1, 0));
        b = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(b[i]);
        ps2_data = b[5];
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(10);
        rst_n = 1'b0;
        wait_cyc(1);
        @(negedge clk);
        check("mr.char", int'(character), 0);
        check("mr.bv", int'(byte_valid), 0);
        check("mr.fe", int'(frame_error), 0);
        rst_n = 1'b1;
        m_char = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
        wait_cyc(30);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(100);
        run_vec("mr.next", mk(0, 8'h2E, 0, 0, 8'h2E, 1, 0));

        // Random frames against the reference model
        for (int n = 0; n < 30; n++) begin
            bit acc;
            case ($urandom_range(0, 7))
                0: b = 8'hF0;
                1: b = 8'hE0;
                2, 7: b = 8'h32;
                3: b = 8'h34;
                4: b = 8'h2E;
                default: b = 8'($urandom_range(0, 255));
            endcase
            v = mk(0, b, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, 8'h00, 0, 0);
            acc = !v.stop_bad && !(v.par_bad && CHK);
            v.exp_bv = acc ? 1 : 0;
            v.exp_fe = acc ? 0 : 1;
            begin
                logic [7:0] sc; bit sb, se;
                sc = m_char; sb = m_brk; se = m_ext;
                if (acc) model_byte(b);
                v.exp_char = m_char;
                m_char = sc; m_brk = sb; m_ext = se;
            end
            run_vec($sformatf("rnd%0d_%02h", n, b), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog expired at cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
